// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and default widths for the AXI-Stream packet generator.
package axis_pkt_gen_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 16;

    // GAP is only reachable when AXIS_PKT_GEN_GAP_EN is defined.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream bus (data, valid, ready, last) with master/slave views.
interface axis_pkt_gen_if
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: on start emits pkt_count packets of pkt_len
// beats with an incrementing data pattern and tlast on each final beat.
// Optional inter-packet idle gap compiled in with AXIS_PKT_GEN_GAP_EN.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [LEN_WIDTH-1:0]  pkt_count,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  gap_len,
    axis_pkt_gen_if.master        m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  pkts_sent
);

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;

`ifdef AXIS_PKT_GEN_GAP_EN
    logic [LEN_WIDTH-1:0]  gap_q;
    logic [LEN_WIDTH-1:0]  gap_cnt;
`else
    logic                  unused_gap;
    assign unused_gap = ^gap_len;
`endif

    logic [LEN_WIDTH-1:0]  eff_len;
    logic [LEN_WIDTH-1:0]  beat_inc;
    logic [LEN_WIDTH-1:0]  len_m1;
    logic [LEN_WIDTH-1:0]  pkts_inc;
    logic                  hs;
    logic                  last_pkt;

    // Derived comparisons used by the FSM (a zero length behaves as one).
    always_comb begin
        eff_len  = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
        beat_inc = LEN_WIDTH'(beat_cnt + 1'b1);
        len_m1   = LEN_WIDTH'(len_q - 1'b1);
        pkts_inc = LEN_WIDTH'(pkts_sent + 1'b1);
        hs       = tvalid_q & m_axis.tready;
        last_pkt = (cnt_q != '0) && (pkts_inc == cnt_q);
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    // Run FSM; all outputs are registered, tlast precomputed for the next beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            beat_cnt  <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkts_sent <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q     <= '0;
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q     <= eff_len;
                        cnt_q     <= pkt_count;
`ifdef AXIS_PKT_GEN_GAP_EN
                        gap_q     <= gap_len;
`endif
                        pkts_sent <= '0;
                        beat_cnt  <= '0;
                        tdata_q   <= seed;
                        tvalid_q  <= 1'b1;
                        tlast_q   <= (eff_len == LEN_WIDTH'(1));
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (hs) begin
                        tdata_q <= tdata_q + 1'b1;
                        if (tlast_q) begin
                            beat_cnt <= '0;
                            if (pkts_sent != '1) begin
                                pkts_sent <= pkts_inc;
                            end
                            if (last_pkt || stop) begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                done     <= 1'b1;
                                state    <= FIN;
                            end
`ifdef AXIS_PKT_GEN_GAP_EN
                            else if (gap_q != '0) begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                gap_cnt  <= gap_q;
                                state    <= GAP;
                            end
`endif
                            else begin
                                tlast_q <= (len_q == LEN_WIDTH'(1));
                            end
                        end else begin
                            beat_cnt <= beat_inc;
                            tlast_q  <= (beat_inc == len_m1);
                        end
                    end
                end

`ifdef AXIS_PKT_GEN_GAP_EN
                // gap_cnt counts the idle cycles still owed; valid rises after the last.
                GAP: begin
                    if (stop) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (gap_cnt == LEN_WIDTH'(1)) begin
                        tvalid_q <= 1'b1;
                        tlast_q  <= (len_q == LEN_WIDTH'(1));
                        state    <= SEND;
                    end else begin
                        gap_cnt <= LEN_WIDTH'(gap_cnt - 1'b1);
                    end
                end
`endif

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: randomized runs compared against a
// beat-list reference model derived from the run configuration.
module tb_axis_pkt_gen;
    import axis_pkt_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [15:0] pkt_count = '0;
    logic [7:0]  seed = '0;
    logic [15:0] gap_len = '0;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    axis_pkt_gen_if #(.DATA_WIDTH(8)) axis ();

    axis_pkt_gen #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pkt_len  (pkt_len),
        .pkt_count(pkt_count),
        .seed     (seed),
        .gap_len  (gap_len),
        .m_axis   (axis),
        .busy     (busy),
        .done     (done),
        .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run: drive start, collect handshakes, then compare with the model.
    task automatic run(input string name, input int len, input int count, input logic [7:0] sd,
                       input int gap, input int ready_pct, input int stop_at);
        int          eff;
        int          eg;
        int          npk;
        int          total;
        int          s_edge;
        int          done_cyc = -1;
        int          last_hs  = -1;
        int          done_seen = 0;
        bit          finished = 1'b0;
        bit          pend = 1'b0;
        logic [7:0]  pd = '0;
        logic        pl = 1'b0;
        logic [7:0]  got_d[$];
        logic        got_l[$];
        int          got_c[$];
        logic [7:0]  exp_d;

        eff = (len == 0) ? 1 : len;
`ifdef AXIS_PKT_GEN_GAP_EN
        eg = gap;
`else
        eg = 0;
`endif
        npk = (count != 0) ? count : (stop_at / eff + 1);
        total = npk * eff;

        pkt_len = 16'(len);
        pkt_count = 16'(count);
        seed = sd;
        gap_len = 16'(gap);
        stop = 1'b0;
        axis.tready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        s_edge = cyc;
        // Config must have been latched; scramble the inputs.
        pkt_len = 16'($urandom);
        pkt_count = 16'($urandom);
        seed = 8'($urandom);
        gap_len = 16'($urandom);

        check_eq({name, ".first_valid"}, axis.tvalid, 1);
        check_eq({name, ".first_data"}, axis.tdata, sd);
        check_eq({name, ".busy"}, busy, 1);

        for (int t = 0; t < 3000 && !finished; t++) begin
            if (pend) begin
                check_eq({name, ".hold_valid"}, axis.tvalid, 1);
                check_eq({name, ".hold_data"}, axis.tdata, pd);
                check_eq({name, ".hold_last"}, axis.tlast, pl);
            end
            check_eq({name, ".pkts_sent_live"}, pkts_sent, 64'(got_d.size() / eff));
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check_eq({name, ".done_width"}, done, 0);
                check_eq({name, ".busy_end"}, busy, 0);
                finished = 1'b1;
            end else begin
                if (done) begin
                    done_seen++;
                    if (done_cyc < 0) done_cyc = cyc;
                    check_eq({name, ".valid_at_done"}, axis.tvalid, 0);
                end
                axis.tready = ($urandom_range(99) < ready_pct);
                if (stop_at > 0 && got_d.size() >= stop_at) stop = 1'b1;
                if (axis.tvalid && axis.tready) begin
                    got_d.push_back(axis.tdata);
                    got_l.push_back(axis.tlast);
                    got_c.push_back(cyc + 1);
                    last_hs = cyc + 1;
                end
                pend = axis.tvalid && !axis.tready;
                pd = axis.tdata;
                pl = axis.tlast;
                start = (ready_pct < 100 && done_cyc < 0 && $urandom_range(9) == 0);
                step();
            end
        end
        start = 1'b0;
        stop = 1'b0;

        check_eq({name, ".terminated"}, finished, 1);
        check_eq({name, ".done_pulses"}, done_seen, 1);
        check_eq({name, ".done_after_last"}, done_cyc, last_hs);
        check_eq({name, ".beat_count"}, got_d.size(), total);
        check_eq({name, ".pkts_sent"}, pkts_sent, npk);
        for (int i = 0; i < got_d.size() && i < total; i++) begin
            exp_d = sd + 8'(i);
            check_eq($sformatf("%s.data[%0d]", name, i), got_d[i], exp_d);
            check_eq($sformatf("%s.last[%0d]", name, i), got_l[i], ((i % eff) == eff - 1));
            if (ready_pct >= 100)
                check_eq($sformatf("%s.cycle[%0d]", name, i), got_c[i], s_edge + 1 + i + (i / eff) * eg);
        end
    endtask

    initial begin
        axis.tready = 1'b0;
        #1;
        check_eq("reset.tvalid", axis.tvalid, 0);
        check_eq("reset.tlast", axis.tlast, 0);
        check_eq("reset.tdata", axis.tdata, 0);
        check_eq("reset.busy", busy, 0);
        check_eq("reset.done", done, 0);
        check_eq("reset.pkts_sent", pkts_sent, 0);
        repeat (3) step();
        reset = 1'b0;
        step();

        // Stop while idle has no effect.
        stop = 1'b1;
        repeat (3) step();
        check_eq("idle_stop.busy", busy, 0);
        check_eq("idle_stop.tvalid", axis.tvalid, 0);
        stop = 1'b0;
        step();

        run("basic", 4, 2, 8'h10, 0, 100, 0);
        step();
        run("backpressure", 4, 2, 8'h10, 0, 50, 0);
        run("wrap_len0", 0, 3, 8'hFE, 0, 100, 0);
        run("cont_stop", 5, 0, 8'h33, 0, 100, 12);
        run("gap", 2, 2, 8'h80, 3, 100, 0);
        run("gap_bp", 3, 3, 8'hC0, 2, 60, 0);

        for (int r = 0; r < 6; r++) begin
            run($sformatf("rand%0d", r), int'($urandom_range(6)), int'($urandom_range(4, 1)),
                8'($urandom), int'($urandom_range(3)), int'($urandom_range(100, 30)), 0);
        end

        // Reset in the middle of a packet, then a clean restart.
        pkt_len = 16'd4;
        pkt_count = 16'd1;
        seed = 8'h22;
        axis.tready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 20 && axis.tdata != 8'h23; t++) step();
        check_eq("rst_mid.reached_beat2", axis.tdata, 8'h23);
        reset = 1'b1;
        #1;
        check_eq("rst_mid.tvalid", axis.tvalid, 0);
        check_eq("rst_mid.tlast", axis.tlast, 0);
        check_eq("rst_mid.tdata", axis.tdata, 0);
        check_eq("rst_mid.busy", busy, 0);
        check_eq("rst_mid.done", done, 0);
        check_eq("rst_mid.pkts_sent", pkts_sent, 0);
        step();
        reset = 1'b0;
        step();
        run("after_reset", 4, 1, 8'h40, 0, 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream packet transmitter: on a start pulse it emits a configurable number of packets, each of a configurable beat count, carrying an incrementing data pattern with `tlast` on the final beat of each packet. It is the master end of our AXIS pipelines. It feeds register stages, FIFOs and sinks in bring-up and loopback test builds. It honours full AXIS backpressure.

## Interface
- `DATA_WIDTH`, 8, width of `m_axis_tdata`.
- `LEN_WIDTH`, 16, width of packet-length, packet-count and gap fields.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `stop`  in  1  level; finish current packet, then return to IDLE.
- `pkt_len`  in  LEN_WIDTH  beats per packet; 0 treated as 1.
- `pkt_count`  in  LEN_WIDTH  packets per run; 0 = run until `stop`.
- `seed`  in  DATA_WIDTH  data value of the first beat of the run.
- `gap_len`  in  LEN_WIDTH  idle cycles between packets (only with `AXIS_PKT_GEN_GAP_EN`).
- `m_axis_tdata`  out  DATA_WIDTH  payload.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  final beat of packet.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pkts_sent`  out  LEN_WIDTH  packets completed in current/last run.

## Operation
- `pkt_len`, `pkt_count`, `seed` and `gap_len` are latched on accepted `start`. Later changes have no effect until the next run.
- States: IDLE, SEND, GAP, FIN.
  - IDLE: `start` → SEND. Latch config, clear `pkts_sent`, load data counter with `seed`.
  - SEND: drive beats. A handshake is `tvalid & tready`. Each handshake increments data (mod 2^DATA_WIDTH) and the beat counter.
  - Handshake on the `tlast` beat increments `pkts_sent`, clears the beat counter, then goes to:
    - FIN if `pkts_sent+1 == pkt_count` (nonzero count) or `stop` is high;
    - otherwise GAP if the gap is enabled and `gap_len != 0`;
    - otherwise stays in SEND.
  - GAP: `tvalid` low for exactly `gap_len` cycles, then SEND.
  - FIN: `done`=1 for one cycle, then IDLE.
- Data counter runs continuously across packets within a run and is not reset per packet. It wraps 0xFF→0x00 at the default width.
- `m_axis_tlast` = (beat counter == latched length−1) while `tvalid`.
- Once `tvalid` is high, `tdata`, `tlast` and `tvalid` hold stable until handshake (AXIS rule). `tvalid` never depends combinationally on `tready`.
- `stop` does not truncate a packet. `stop` in GAP goes to FIN immediately. `stop` in IDLE is ignored.
- `start` outside IDLE is ignored.
- Reset (any cycle, incl. mid-packet) drives all outputs to 0 asynchronously:
  - `tvalid`, `tlast`, `tdata`, `busy`, `done`, `pkts_sent` = 0;
  - state = IDLE.
  - The partial packet is abandoned.
- Counter widths:
  - beat counter LEN_WIDTH;
  - `pkts_sent` LEN_WIDTH, saturating at all-ones in count-0 mode.

## Timing
- All outputs are registered.
- `start` at cycle N → `busy`=1 and `tvalid`=1 with `tdata`=`seed` at N+1.
- With `tready` held high: one beat per cycle. No bubble between packets when the gap is disabled or zero.
- Last handshake of the run at cycle M:
  - `tvalid`=0 and `done`=1 at M+1;
  - `busy`=0 and `done`=0 at M+2.
- `pkts_sent` updates in the cycle after each `tlast` handshake.
- The earliest new `start` is accepted at M+2.

## Configuration
- `AXIS_PKT_GEN_GAP_EN` defined:
  - GAP state, gap counter and `gap_len` latch are compiled in;
  - `gap_len` cycles of `tvalid`=0 separate packets.
- Not defined:
  - no GAP state or gap counter; `gap_len` is ignored (port retained, unused);
  - packets are back-to-back.

## Structure
- Shared package `axis_pkt_gen_pkg` holds:
  - state enum typedef (IDLE, SEND, GAP, FIN);
  - default width constants.
- No sub-module: a single FSM plus counters. Output register stages are instantiated externally by the integrator.

## Test plan
- Basic run: `pkt_len`=4, `pkt_count`=2, `seed`=0x10, `tready`=1 → beats 0x10..0x17, `tlast` on 0x13 and 0x17; `done` one cycle after 0x17; `pkts_sent`=2.
- Backpressure: same config, `tready` toggling pseudo-randomly → identical beat sequence; `tdata`/`tlast` stable while `tvalid & !tready`; no beat dropped or duplicated.
- Wrap and length 0: `seed`=0xFE, `pkt_len`=0, `pkt_count`=3 → three single-beat packets 0xFE, 0xFF, 0x00, each with `tlast`=1.
- Continuous plus stop: `pkt_count`=0, `pkt_len`=5, `stop` raised mid-third packet → third packet completes all 5 beats, then `done`; `pkts_sent`=3.
- Gap (macro defined): `pkt_len`=2, `gap_len`=3, `pkt_count`=2 → exactly 3 cycles of `tvalid`=0 between packets. Macro undefined → 0 idle cycles.
- Reset mid-packet: assert `reset` on beat 2 of 4 → all outputs 0 immediately. After release, a new `start` with `seed`=0x40 restarts cleanly at 0x40.
